bin_to_bcd_seq: RTL and testbench
=================================

# bin_to_bcd_seq

Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) that sits directly downstream of the calculator's adder. It takes the adder's N-bit `Sum` word, optionally interpreted as two's complement, and produces DIGITS packed BCD digits, a sign flag and a leading-zero blank mask for the display driver. It uses a start/busy/done handshake so the adder result only has to be valid in the start cycle.

## Interface
- `N`, default 8: width of the binary input; must be ≥ 2.
- `DIGITS`, default 3: number of BCD output digits; must satisfy 10^DIGITS > 2^N − 1. The build fails otherwise.
- `SIGNED`, default 0: 1 treats `bin` as two's complement; 0 treats it as unsigned.
- `clk` input, 1 bit: the single clock; every register updates on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `start` input, 1 bit: request a conversion of `bin`; sampled only when idle.
- `bin` input, N bits: binary operand (adder `Sum`); sampled only on the accepting edge.
- `busy` output, 1 bit: a conversion is in progress.
- `done` output, 1 bit: one-cycle pulse; results are updated in the same cycle.
- `bcd` output, 4·DIGITS bits: packed BCD, least significant digit in [3:0]; held until the next `done`.
- `neg` output, 1 bit: result is negative (SIGNED=1 only, else constant 0); held with `bcd`.
- `blank` output, DIGITS bits: bit k=1 means digit k is a leading zero; bit 0 is always 0; held with `bcd`.

## Operation
- FSM has two states, IDLE and SHIFT, plus a bit counter of width clog2(N+1).
- IDLE with `start`=1 (the accepting edge):
  - Compute magnitude `mag`: if SIGNED=1 and bin[N−1]=1, `mag` = (~bin + 1) taken as N-bit unsigned; otherwise `mag` = bin.
  - Note: −2^(N−1) gives `mag` = 2^(N−1), which is representable.
  - Capture `mag` into the binary shift register and the sign into a pending-sign bit.
  - Clear the DIGITS×4 scratch register, set counter = N, go to SHIFT.
- SHIFT, every edge:
  - Each scratch digit ≥ 5 gets 3 added to it (4-bit add, no carry between digits).
  - Then shift {scratch, binary} left by one, with the binary MSB entering scratch bit 0.
  - Decrement the counter.
- SHIFT, edge where counter = 1 (the final shift):
  - Load `bcd` with the post-shift scratch value, `neg` with the pending sign, and `blank` from it.
  - `blank` rule: digit k (k ≥ 1) is blanked iff it and all higher digits are zero.
  - Assert `done`, go to IDLE.
- `start` while in SHIFT is ignored; there is no queueing.
- `start` in the cycle `done` is high is accepted (FSM is IDLE), so back-to-back conversions are possible.
- `bin` changing after the accepting edge has no effect.
- Zero result: `bcd`=0, `blank`={1…1,0}, `neg`=0. A negative zero cannot occur.

## Timing
- Reset values: `busy`=0, `done`=0, `bcd`=0, `neg`=0, `blank`={1…1,0}; FSM in IDLE, counter 0.
- Accepting edge E0 is followed by N SHIFT edges E1…EN.
- `busy`=1 in the cycles after E0 through EN−1; it is combinational from the state (SHIFT).
- `done`=1 and new `bcd`/`neg`/`blank` are visible in the cycle after EN; `busy` is 0 in that cycle.
- Latency: N+1 rising edges from the edge sampling `start` to the edge at which `done` is first observed high. This is 9 for N=8.
- Throughput: one conversion per N+1 cycles with back-to-back starts.
- `rst` mid-conversion: next cycle is IDLE with all outputs at reset values. No `done` pulse occurs and the previous `bcd` is lost.
- `rst` and `start` high together: reset wins and the request is dropped.

## Test plan
- N=8, SIGNED=0, bin=0xFF, pulse start: `busy` high for 8 cycles, `done` on the 9th edge, `bcd`=0x255, `blank`=3'b000, `neg`=0.
- bin=0x00: `bcd`=0x000, `blank`=3'b110. Then bin=0x07: `bcd`=0x007, `blank`=3'b110. Then bin=0x2A: `bcd`=0x042, `blank`=3'b100.
- SIGNED=1, bin=0x80 → `bcd`=0x128, `neg`=1. bin=0xFF → `bcd`=0x001, `neg`=1, `blank`=3'b110. bin=0x7F → `bcd`=0x127, `neg`=0.
- Start bin=0x64, then 3 cycles later start with bin=0x11 while busy: exactly one `done`, `bcd`=0x100. Changing `bin` mid-conversion has no effect.
- Assert `rst` at SHIFT cycle 4 of a bin=0xC8 conversion: no `done`, all outputs at reset values, next start converts normally.
- Hold start high continuously with bin=0xC8 then 0x05: `done` pulses every 9 cycles, `bcd`=0x200 then 0x005, `busy` low only during `done` cycles.

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential shift-and-add-3 binary to packed BCD converter
//
// Converts an N-bit word (unsigned, or two's complement when SIGNED=1) into
// DIGITS packed BCD digits, one binary bit per clock.
//
// Ports:
//   clk    - clock, all registers update on the rising edge
//   rst    - synchronous active-high reset
//   start  - request a conversion of bin; sampled only when idle
//   bin    - binary operand, sampled only on the accepting edge
//   busy   - conversion in progress (SHIFT state)
//   done   - one-cycle pulse, results updated in the same cycle
//   bcd    - packed BCD result, least significant digit in [3:0]
//   neg    - result is negative (always 0 when SIGNED=0)
//   blank  - bit k set when digit k is a leading zero; bit 0 always 0

module bin_to_bcd_seq #(
    parameter int N      = 8,
    parameter int DIGITS = 3,
    parameter int SIGNED = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [N-1:0]        bin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd,
    output logic                neg,
    output logic [DIGITS-1:0]   blank
);

    // True when DIGITS decimal digits can hold 2^N - 1. Returns as soon as
    // the power of ten is large enough so the product never overflows.
    function automatic bit digits_ok();
        logic [127:0] p;
        logic [127:0] lim;
        p   = 128'd1;
        lim = (128'd1 << N) - 128'd1;
        for (int i = 0; i < DIGITS; i++) begin
            p = p * 128'd10;
            if (p > lim) return 1'b1;
        end
        return 1'b0;
    endfunction

    if (N < 2 || !digits_ok()) begin : g_param_check
        $error("bin_to_bcd_seq: N must be >= 2 and 10**DIGITS must exceed 2**N - 1");
    end

    localparam int CW = $clog2(N + 1);
    localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} << 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [N-1:0]        bin_sr;
    logic [4*DIGITS-1:0] scratch;
    logic                neg_pend;

    logic                sign_in;
    logic [N-1:0]        mag;
    logic [4*DIGITS-1:0] adj;
    logic [4*DIGITS-1:0] shifted;
    logic [DIGITS-1:0]   blank_next;
    logic                hi_zero;

    assign busy = (state == SHIFT);

    always_comb begin
        sign_in    = (SIGNED != 0) && bin[N-1];
        // -2^(N-1) negates to itself, which read as unsigned is the right magnitude.
        mag        = sign_in ? (~bin + N'(1)) : bin;
        adj        = '0;
        shifted    = '0;
        blank_next = '0;
        hi_zero    = 1'b1;

        for (int k = 0; k < DIGITS; k++) begin
            adj[4*k +: 4] = (scratch[4*k +: 4] >= 4'd5) ? scratch[4*k +: 4] + 4'd3
                                                         : scratch[4*k +: 4];
        end
        shifted = {adj[4*DIGITS-2:0], bin_sr[N-1]};

        // Walk from the top digit down; a digit is blank only while every
        // digit above it is also zero. The units digit is never blanked.
        for (int k = DIGITS - 1; k >= 1; k--) begin
            hi_zero       = hi_zero && (shifted[4*k +: 4] == 4'd0);
            blank_next[k] = hi_zero;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            bin_sr   <= '0;
            scratch  <= '0;
            neg_pend <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            neg      <= 1'b0;
            blank    <= BLANK_RST;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bin_sr   <= mag;
                        neg_pend <= sign_in;
                        scratch  <= '0;
                        cnt      <= CW'(N);
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch <= shifted;
                    bin_sr  <= {bin_sr[N-2:0], 1'b0};
                    cnt     <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        bcd   <= shifted;
                        neg   <= neg_pend;
                        blank <= blank_next;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - self-checking bench for bin_to_bcd_seq (unsigned and signed instances)

module tb_bin_to_bcd_seq;

    logic        clk;
    logic        rst;
    logic        start_u, start_s;
    logic [7:0]  bin;
    logic        busy_u, done_u, neg_u;
    logic [11:0] bcd_u;
    logic [2:0]  blank_u;
    logic        busy_s, done_s, neg_s;
    logic [11:0] bcd_s;
    logic [2:0]  blank_s;

    bit          sel;
    logic        o_busy, o_done, o_neg;
    logic [11:0] o_bcd;
    logic [2:0]  o_blank;

    int n_chk  = 0;
    int n_fail = 0;

    bin_to_bcd_seq #(.N(8), .DIGITS(3), .SIGNED(0)) u_uns (
        .clk(clk), .rst(rst), .start(start_u), .bin(bin),
        .busy(busy_u), .done(done_u), .bcd(bcd_u), .neg(neg_u), .blank(blank_u)
    );

    bin_to_bcd_seq #(.N(8), .DIGITS(3), .SIGNED(1)) u_sgn (
        .clk(clk), .rst(rst), .start(start_s), .bin(bin),
        .busy(busy_s), .done(done_s), .bcd(bcd_s), .neg(neg_s), .blank(blank_s)
    );

    assign o_busy  = sel ? busy_s  : busy_u;
    assign o_done  = sel ? done_s  : done_u;
    assign o_bcd   = sel ? bcd_s   : bcd_u;
    assign o_neg   = sel ? neg_s   : neg_u;
    assign o_blank = sel ? blank_s : blank_u;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: decimal digits straight from integer division of the magnitude.
    task automatic model(input logic [7:0] b, input bit s,
                         output logic [11:0] eb, output logic en, output logic [2:0] ebl);
        int v;
        en  = s && b[7];
        v   = en ? 256 - int'(b) : int'(b);
        eb  = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
        ebl = {v < 100, v < 10, 1'b0};
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"},  32'(o_busy),  32'd0);
        chk({tag, "_done"},  32'(o_done),  32'd0);
        chk({tag, "_bcd"},   32'(o_bcd),   32'd0);
        chk({tag, "_neg"},   32'(o_neg),   32'd0);
        chk({tag, "_blank"}, 32'(o_blank), 32'b110);
    endtask

    // Called on a negedge with the selected DUT idle; returns on the negedge after done drops.
    task automatic convert(input bit s, input logic [7:0] b);
        logic [11:0] eb;
        logic        en;
        logic [2:0]  ebl;
        int          cyc;
        int          nbusy;
        model(b, s, eb, en, ebl);
        sel = s;
        bin = b;
        if (s) start_s = 1'b1; else start_u = 1'b1;
        @(negedge clk);
        start_u = 1'b0;
        start_s = 1'b0;
        bin     = 8'($urandom);
        cyc     = 1;
        nbusy   = 0;
        while (!o_done && cyc < 20) begin
            if (o_busy) nbusy++;
            @(negedge clk);
            cyc++;
        end
        chk("latency",      32'(cyc),     32'd9);
        chk("busy_cycles",  32'(nbusy),   32'd8);
        chk("busy_at_done", 32'(o_busy),  32'd0);
        chk("bcd",          32'(o_bcd),   32'(eb));
        chk("neg",          32'(o_neg),   32'(en));
        chk("blank",        32'(o_blank), 32'(ebl));
        @(negedge clk);
        chk("done_pulse",   32'(o_done),  32'd0);
        chk("bcd_held",     32'(o_bcd),   32'(eb));
    endtask

    initial begin
        int ndone;
        logic [11:0] seen_bcd;

        rst = 1'b1; start_u = 1'b0; start_s = 1'b0; bin = 8'h00; sel = 1'b0;
        repeat (2) @(negedge clk);
        sel = 1'b0; check_reset_outputs("rst_u");
        sel = 1'b1; check_reset_outputs("rst_s");
        rst = 1'b0;
        @(negedge clk);

        // Directed unsigned values
        convert(1'b0, 8'hFF);
        convert(1'b0, 8'h00);
        convert(1'b0, 8'h07);
        convert(1'b0, 8'h2A);
        convert(1'b0, 8'h63);
        convert(1'b0, 8'h64);

        // Directed signed values, including the most negative input
        convert(1'b1, 8'h80);
        convert(1'b1, 8'hFF);
        convert(1'b1, 8'h7F);
        convert(1'b1, 8'h00);
        convert(1'b1, 8'hF6);

        // Start while busy is ignored; bin changes after acceptance
        sel = 1'b0; bin = 8'h64; start_u = 1'b1;
        @(negedge clk);
        start_u = 1'b0; bin = 8'h99;
        repeat (2) @(negedge clk);
        start_u = 1'b1; bin = 8'h11;
        @(negedge clk);
        start_u = 1'b0; bin = 8'h33;
        ndone = 0; seen_bcd = 12'hFFF;
        for (int i = 0; i < 20; i++) begin
            if (o_done) begin
                ndone++;
                seen_bcd = o_bcd;
            end
            @(negedge clk);
        end
        chk("ignore_start_ndone", 32'(ndone),    32'd1);
        chk("ignore_start_bcd",   32'(seen_bcd), 32'h100);

        // Reset in the middle of a conversion, with start raised alongside it
        sel = 1'b0; bin = 8'hC8; start_u = 1'b1;
        @(negedge clk);
        start_u = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1; start_u = 1'b1;
        @(negedge clk);
        rst = 1'b0; start_u = 1'b0;
        check_reset_outputs("mid_rst");
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (o_done || o_busy) ndone++;
            @(negedge clk);
        end
        chk("mid_rst_quiet", 32'(ndone), 32'd0);
        convert(1'b0, 8'hC8);

        // Start held high: back-to-back conversions
        sel = 1'b0; bin = 8'hC8; start_u = 1'b1;
        @(negedge clk);
        bin = 8'h05;
        for (int idx = 0; idx < 18; idx++) begin
            chk("b2b_done", 32'(o_done), (idx == 8 || idx == 17) ? 32'd1 : 32'd0);
            chk("b2b_busy", 32'(o_busy), 32'(!o_done));
            if (idx == 8)  chk("b2b_bcd0", 32'(o_bcd), 32'h200);
            if (idx == 17) chk("b2b_bcd1", 32'(o_bcd), 32'h005);
            if (idx == 17) start_u = 1'b0;
            @(negedge clk);
        end
        chk("b2b_stop", 32'(o_busy), 32'd0);

        // Random operands on both instances
        for (int i = 0; i < 24; i++) begin
            convert(1'($urandom_range(0, 1)), 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
